// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI responder for all four modes, with SCK/CS/MOSI oversampled in the clk domain.
// Received bytes leave as an rx_valid pulse; bytes to send enter through a one-entry valid/ready holding register.
module spi_slave_sync #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DUMMY       = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCK,
    input  logic       CS,
    input  logic       MOSI,
    output logic       MISO,
    output logic       miso_oe,
    input  logic [1:0] mode,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       underrun,
    output logic       busy
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
    logic sck_prev_q, sck_prev_d, cs_prev_q, cs_prev_d;
    logic cpol_q, cpol_d, cpha_q, cpha_d, pend_q, pend_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, hold_q, hold_d, rx_data_q, rx_data_d;
    logic hold_full_q, hold_full_d, miso_q, miso_d, rx_valid_q, rx_valid_d, underrun_q, underrun_d;
    logic sck_s, cs_s, mosi_s, cs_fall, cs_rise, active, enter, leave, lead, trail, sample, shift, load, tx_acc;
    logic [7:0] src, rx_byte;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        sck_s       = sck_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
        cs_fall     = ~cs_s & cs_prev_q;
        cs_rise     = cs_s & ~cs_prev_q;
        active      = state_q == ACTIVE;
        enter       = ~active & cs_fall;
        leave       = active & cs_rise;
        // Leading edge leaves the CPOL idle level; an edge coinciding with deselect is dropped.
        lead        = cpol_q ? (~sck_s & sck_prev_q) : (sck_s & ~sck_prev_q);
        trail       = cpol_q ? (sck_s & ~sck_prev_q) : (~sck_s & sck_prev_q);
        sample      = active & ~cs_rise & (cpha_q ? trail : lead);
        shift       = active & ~cs_rise & (cpha_q ? lead : trail);
        load        = enter | (shift & pend_q);
        src         = hold_full_q ? hold_q : DUMMY;
        tx_acc      = tx_valid & ~hold_full_q;
        hold_full_d = tx_acc | (hold_full_q & ~load);
        hold_d      = tx_acc ? tx_data : hold_q;
        underrun_d  = load & ~hold_full_q;
        state_d     = enter ? ACTIVE : leave ? IDLE : state_q;
        cpol_d      = enter ? mode[1] : cpol_q;
        cpha_d      = enter ? mode[0] : cpha_q;
        rx_byte     = {rx_sh_q[6:0], mosi_s};
        rx_sh_d     = sample ? rx_byte : rx_sh_q;
        rx_valid_d  = sample && bit_cnt_q == 3'd7;
        rx_data_d   = rx_valid_d ? rx_byte : rx_data_q;
        bit_cnt_d   = (enter || leave) ? 3'd0 : sample ? bit_cnt_q + 3'd1 : bit_cnt_q;
        pend_d      = (enter || leave) ? 1'b0 : rx_valid_d ? 1'b1 : load ? 1'b0 : pend_q;
        tx_sh_d     = tx_sh_q;
        miso_d      = miso_q;
        // A CPHA=1 byte shows its MSB only on its first leading edge, so selection leaves MISO low.
        if (leave)
            miso_d = 1'b0;
        else if (load) begin
            tx_sh_d = src;
            miso_d  = (enter && mode[0]) ? 1'b0 : src[7];
        end else if (shift && bit_cnt_q == 3'd0)
            miso_d = tx_sh_q[7];
        else if (shift) begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            miso_d  = tx_sh_q[6];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            pend_q      <= 1'b0;
            bit_cnt_q   <= 3'd0;
            tx_sh_q     <= 8'h00;
            rx_sh_q     <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            pend_q      <= pend_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            miso_q      <= miso_d;
        end
    end

    assign MISO     = miso_q;
    assign busy     = state_q == ACTIVE;
    assign miso_oe  = busy;
    assign tx_ready = ~hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign underrun = underrun_q;
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: SPI master model driving the slave in all modes; table vectors, corner sequences
// and random transfers are checked against byte-level expectations.
module tb_spi_slave_sync;
    localparam int H = 6;
    localparam logic [7:0] DUMMY = 8'h00;
    logic clk = 1'b0, rst = 1'b1, SCK = 1'b0, CS = 1'b1, MOSI = 1'b0, tx_valid = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] tx_data = 8'h00;
    logic MISO, miso_oe, tx_ready, rx_valid, underrun, busy;
    logic [7:0] rx_data;
    int checks = 0, passes = 0, ur_cnt = 0, ur_pre, ur_data;
    logic [7:0] rx_log[$];
    logic [31:0] m_got;
    logic miso_first;

    spi_slave_sync #(.SYNC_STAGES(2), .DUMMY(DUMMY)) dut (
        .clk(clk), .rst(rst), .SCK(SCK), .CS(CS), .MOSI(MOSI), .MISO(MISO), .miso_oe(miso_oe),
        .mode(mode), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .underrun(underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rx_log.push_back(rx_data);
        if (underrun) ur_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] d);
        int w = 0;
        while (!tx_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("tx_ready_wait", tx_ready, 1'b1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Master: mb holds up to four bytes MSB-first from bit 31; received bits land in m_got likewise.
    task automatic spi_xfer(input logic [1:0] m, input logic [31:0] mb, input int nbits, input bit raise);
        mode  = m;
        SCK   = m[1];
        m_got = '0;
        clks(4);
        CS   = 1'b0;
        MOSI = m[0] ? 1'b0 : mb[31];
        clks(8);
        ur_pre     = ur_cnt;
        miso_first = MISO;
        for (int k = 0; k < nbits; k++) begin
            if (!m[0]) begin
                m_got[31-k] = MISO;
                SCK = ~m[1];
                clks(H);
                if (k == nbits - 1) ur_data = ur_cnt;
                SCK  = m[1];
                MOSI = (k + 1 < nbits) ? mb[30-k] : 1'b0;
                clks(H);
            end else begin
                SCK  = ~m[1];
                MOSI = mb[31-k];
                clks(H);
                if (k == nbits - 1) ur_data = ur_cnt;
                m_got[31-k] = MISO;
                SCK = m[1];
                clks(H);
            end
        end
        if (raise) begin
            CS   = 1'b1;
            MOSI = 1'b0;
            clks(8);
        end
    endtask

    typedef struct {
        logic [1:0] m;
        bit         pre;
        logic [7:0] txb, mb, got, rx;
        int         urd, urt;
        logic       m0;
    } vec_t;
    vec_t vt[6];

    initial begin
        int base_rx, base_ur, n, loads;
        bit pre;
        logic [1:0] m;
        logic [7:0] d, r;
        logic [31:0] mb;
        vt[0] = '{2'd0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0, 1, 1'b1};
        vt[1] = '{2'd3, 1'b1, 8'hC3, 8'h96, 8'hC3, 8'h96, 0, 0, 1'b0};
        vt[2] = '{2'd1, 1'b1, 8'hC3, 8'h96, 8'hC3, 8'h96, 0, 0, 1'b0};
        vt[3] = '{2'd2, 1'b1, 8'hDA, 8'h81, 8'hDA, 8'h81, 0, 1, 1'b1};
        vt[4] = '{2'd0, 1'b0, 8'h00, 8'h7F, 8'h00, 8'h7F, 1, 2, 1'b0};
        vt[5] = '{2'd3, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 1'b0};

        clks(3);
        chk("rst_miso", MISO, 1'b0);
        chk("rst_oe", miso_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        clks(4);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b1);

        foreach (vt[i]) begin
            base_rx = rx_log.size();
            base_ur = ur_cnt;
            if (vt[i].pre) tx_write(vt[i].txb);
            spi_xfer(vt[i].m, {vt[i].mb, 24'h0}, 8, 1'b1);
            r = (rx_log.size() > base_rx) ? rx_log[base_rx] : 8'hxx;
            chk($sformatf("vec%0d_master_rx", i), m_got[31:24], vt[i].got);
            chk($sformatf("vec%0d_rx_count", i), rx_log.size() - base_rx, 1);
            chk($sformatf("vec%0d_rx_data", i), r, vt[i].rx);
            chk($sformatf("vec%0d_miso_first", i), miso_first, vt[i].m0);
            chk($sformatf("vec%0d_ur_data", i), ur_data - base_ur, vt[i].urd);
            chk($sformatf("vec%0d_ur_total", i), ur_cnt - base_ur, vt[i].urt);
            chk($sformatf("vec%0d_idle", i), {busy, miso_oe, MISO, tx_ready}, 4'b0001);
        end

        // Two bytes under one CS, second TX byte written while the first is shifting.
        tx_write(8'h11);
        base_rx = rx_log.size();
        fork
            spi_xfer(2'd0, 32'hA00B_0000, 16, 1'b1);
            tx_write(8'h22);
        join
        chk("b2b_master_rx", m_got[31:16], 16'h1122);
        chk("b2b_rx_count", rx_log.size() - base_rx, 2);
        r = (rx_log.size() > base_rx + 1) ? rx_log[base_rx+1] : 8'hxx;
        chk("b2b_rx_data", {rx_log.size() > base_rx ? rx_log[base_rx] : 8'hxx, r}, 16'hA00B);
        chk("b2b_tx_ready", tx_ready, 1'b1);

        // Underrun at selection; a mid-byte write goes out in the following byte.
        base_rx = rx_log.size();
        base_ur = ur_cnt;
        fork
            spi_xfer(2'd0, 32'hA1B2_0000, 16, 1'b1);
            begin
                clks(30);
                tx_write(8'h3E);
            end
        join
        chk("ur_at_select", ur_pre - base_ur, 1);
        chk("ur_master_rx", m_got[31:16], {DUMMY, 8'h3E});
        chk("ur_rx_count", rx_log.size() - base_rx, 2);

        // Abort after five SCK cycles, then a full byte.
        base_rx = rx_log.size();
        spi_xfer(2'd0, 32'hFFFF_0000, 5, 1'b1);
        chk("abort_no_rx", rx_log.size() - base_rx, 0);
        spi_xfer(2'd1, 32'h5A00_0000, 8, 1'b1);
        r = (rx_log.size() > base_rx) ? rx_log[base_rx] : 8'hxx;
        chk("abort_next_count", rx_log.size() - base_rx, 1);
        chk("abort_next_rx", r, 8'h5A);

        // Reset at bit 4 with a byte held, then a clean byte.
        tx_write(8'h77);
        spi_xfer(2'd0, 32'h1234_0000, 4, 1'b0);
        tx_write(8'h99);
        chk("pre_rst_tx_ready", tx_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {MISO, miso_oe, rx_valid, underrun, busy, tx_ready}, 6'b000001);
        chk("mid_rst_rx_data", rx_data, 8'h00);
        CS = 1'b1;
        SCK = 1'b0;
        clks(3);
        rst = 1'b0;
        clks(6);
        chk("post_rst_busy", busy, 1'b0);
        base_rx = rx_log.size();
        base_ur = ur_cnt;
        spi_xfer(2'd0, 32'hF000_0000, 8, 1'b1);
        r = (rx_log.size() > base_rx) ? rx_log[base_rx] : 8'hxx;
        chk("post_rst_rx", r, 8'hF0);
        chk("post_rst_master_rx", m_got[31:24], DUMMY);
        chk("post_rst_ur_select", ur_pre - base_ur, 1);

        // Random transfers against a byte-level model.
        for (int t = 0; t < 25; t++) begin
            m  = 2'($urandom_range(0, 3));
            n  = $urandom_range(1, 3);
            pre = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            mb = $urandom;
            base_rx = rx_log.size();
            base_ur = ur_cnt;
            if (pre) tx_write(d);
            spi_xfer(m, mb, 8 * n, 1'b1);
            loads = n + (m[0] ? 0 : 1);
            chk($sformatf("rnd%0d_rx_count", t), rx_log.size() - base_rx, n);
            chk($sformatf("rnd%0d_underruns", t), ur_cnt - base_ur, loads - int'(pre));
            for (int b = 0; b < n; b++) begin
                r = (rx_log.size() > base_rx + b) ? rx_log[base_rx+b] : 8'hxx;
                chk($sformatf("rnd%0d_b%0d_rx", t, b), r, mb[31-8*b -: 8]);
                chk($sformatf("rnd%0d_b%0d_master", t, b), m_got[31-8*b -: 8], (b == 0 && pre) ? d : DUMMY);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
